// File: rtl/cv32e40p_fetch_aligner_if.sv
// Handshake and bus bundle between the prefetch buffer, the fetch aligner and the IF stage.
// The master modport is the aligner side; the slave modport is its environment.
interface cv32e40p_fetch_aligner_if;
    localparam int unsigned XLEN = 32;

    logic            fetch_valid_i;
    logic            fetch_ready_o;
    logic [XLEN-1:0] fetch_rdata_i;
    logic            if_valid_i;
    logic [XLEN-1:0] instr_aligned_o;
    logic            instr_valid_o;
    logic            branch_i;
    logic [XLEN-1:0] branch_addr_i;
    logic            hwlp_update_pc_i;
    logic [XLEN-1:0] hwlp_addr_i;
    logic [XLEN-1:0] pc_o;

    modport master (
        input  fetch_valid_i, fetch_rdata_i, if_valid_i, branch_i, branch_addr_i,
               hwlp_update_pc_i, hwlp_addr_i,
        output fetch_ready_o, instr_aligned_o, instr_valid_o, pc_o
    );

    modport slave (
        output fetch_valid_i, fetch_rdata_i, if_valid_i, branch_i, branch_addr_i,
               hwlp_update_pc_i, hwlp_addr_i,
        input  fetch_ready_o, instr_aligned_o, instr_valid_o, pc_o
    );
endinterface

// File: rtl/cv32e40p_fetch_aligner.sv
// IF-stage instruction aligner: turns word-aligned fetch words into whole 16/32-bit instructions
// and owns the IF pc. Define CV32E40P_ALIGNER_HWLP_EN to honour hardware-loop redirects.
module cv32e40p_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                       clk,
    input logic                       rst_n,
    cv32e40p_fetch_aligner_if.master  bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned HLEN = 16;

    typedef enum logic [1:0] {
        ALIGNED32    = 2'd0,
        MISALIGNED32 = 2'd1,
        MISALIGNED16 = 2'd2
    } state_e;

    state_e          r_state;
    logic [XLEN-1:0] r_pc;
    logic [HLEN-1:0] r_half;

    logic [HLEN-1:0] w_sel_half;
    logic            w_is32;
    logic [XLEN-1:0] w_instr;
    logic            w_valid;
    logic            w_ready;
    logic            w_redir;
    logic [XLEN-1:0] w_redir_addr;

    // Halfword at which the current instruction starts
    always_comb begin
        w_sel_half = bus.fetch_rdata_i[15:0];
        case (r_state)
            MISALIGNED32: w_sel_half = r_half;
            MISALIGNED16: w_sel_half = bus.fetch_rdata_i[31:16];
            default:      w_sel_half = bus.fetch_rdata_i[15:0];
        endcase
    end

    assign w_is32 = (w_sel_half[1:0] == 2'b11);

    // Instruction assembly and handshake; a pending branch squashes both
    always_comb begin
        w_instr = {HLEN'(0), w_sel_half};
        w_valid = 1'b0;
        w_ready = 1'b1;
        case (r_state)
            MISALIGNED32: begin
                if (w_is32) begin
                    w_instr = {bus.fetch_rdata_i[15:0], r_half};
                    w_valid = bus.fetch_valid_i;
                end else begin
                    w_valid = 1'b1;
                    w_ready = 1'b0;
                end
            end
            MISALIGNED16: begin
                w_valid = w_is32 ? 1'b0 : bus.fetch_valid_i;
            end
            default: begin
                w_valid = bus.fetch_valid_i;
                if (w_is32) begin
                    w_instr = bus.fetch_rdata_i;
                end
            end
        endcase
        if (bus.branch_i) begin
            w_valid = 1'b0;
            w_ready = 1'b0;
        end
    end

`ifdef CV32E40P_ALIGNER_HWLP_EN
    // Hardware-loop jump only redirects when the instruction actually issues
    assign w_redir      = bus.branch_i |
                          (bus.hwlp_update_pc_i & bus.if_valid_i & w_valid);
    assign w_redir_addr = bus.branch_i ? bus.branch_addr_i : bus.hwlp_addr_i;
`else
    assign w_redir      = bus.branch_i;
    assign w_redir_addr = bus.branch_addr_i;
`endif

    assign bus.instr_aligned_o = w_instr;
    assign bus.instr_valid_o   = w_valid;
    assign bus.fetch_ready_o   = w_ready;
    assign bus.pc_o            = r_pc;

    // State, pc and buffered upper halfword
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ALIGNED32;
            r_pc    <= RESET_PC;
            r_half  <= HLEN'(0);
        end else if (w_redir) begin
            r_pc    <= {w_redir_addr[31:1], 1'b0};
            r_state <= w_redir_addr[1] ? MISALIGNED16 : ALIGNED32;
            r_half  <= HLEN'(0);
        end else if (bus.if_valid_i) begin
            case (r_state)
                MISALIGNED32: begin
                    if (w_is32) begin
                        r_half <= bus.fetch_rdata_i[31:16];
                        r_pc   <= r_pc + XLEN'(4);
                    end else begin
                        r_pc    <= r_pc + XLEN'(2);
                        r_state <= ALIGNED32;
                    end
                end
                MISALIGNED16: begin
                    if (w_is32) begin
                        // Straddling instruction: keep pc, wait for the next word
                        r_half  <= bus.fetch_rdata_i[31:16];
                        r_state <= MISALIGNED32;
                    end else begin
                        r_pc    <= r_pc + XLEN'(2);
                        r_state <= ALIGNED32;
                    end
                end
                default: begin
                    if (w_is32) begin
                        r_pc <= r_pc + XLEN'(4);
                    end else begin
                        r_half  <= bus.fetch_rdata_i[31:16];
                        r_pc    <= r_pc + XLEN'(2);
                        r_state <= MISALIGNED32;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cv32e40p_fetch_aligner.sv
// Directed bench for cv32e40p_fetch_aligner against a halfword-stream model of the IF fetch path.
module tb_cv32e40p_fetch_aligner;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    cv32e40p_fetch_aligner_if bus ();

    cv32e40p_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: pc plus a queue of fetched-but-unissued halfwords in program order
    logic [31:0] m_pc;
    logic [15:0] m_q[$];
    logic        m_skip;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is32(input logic [15:0] h);
        return h[1:0] == 2'b11;
    endfunction

    function automatic void model_eval(output logic v, output logic r,
                                       output logic [31:0] ins, output int n);
        logic [15:0] avail[$];
        v = 1'b0; r = 1'b0; ins = 32'h0; n = 0;
        if (bus.branch_i) return;
        if (m_q.size() > 0 && !is32(m_q[0])) begin
            v = 1'b1; ins = {16'h0, m_q[0]}; n = 1;
            return;
        end
        r = 1'b1;
        avail = m_q;
        if (bus.fetch_valid_i) begin
            if (!m_skip) avail.push_back(bus.fetch_rdata_i[15:0]);
            avail.push_back(bus.fetch_rdata_i[31:16]);
        end
        if (avail.size() == 0) return;
        if (!is32(avail[0])) begin
            v = 1'b1; ins = {16'h0, avail[0]}; n = 1;
        end else if (avail.size() >= 2) begin
            v = 1'b1; ins = {avail[1], avail[0]}; n = 2;
        end
    endfunction

    function automatic void model_redirect(input logic [31:0] a);
        m_pc   = {a[31:1], 1'b0};
        m_q    = {};
        m_skip = a[1];
    endfunction

    function automatic void model_reset();
        m_pc = 32'h0; m_q = {}; m_skip = 1'b0;
    endfunction

    task automatic drive(input logic fv, input logic [31:0] rd, input logic iv,
                         input logic br, input logic [31:0] ba,
                         input logic hw, input logic [31:0] ha);
        bus.fetch_valid_i    = fv;
        bus.fetch_rdata_i    = rd;
        bus.if_valid_i       = iv;
        bus.branch_i         = br;
        bus.branch_addr_i    = ba;
        bus.hwlp_update_pc_i = hw;
        bus.hwlp_addr_i      = ha;
    endtask

    // Compare at negedge, optionally pin literal values, then advance the model across the posedge
    task automatic tick(input string tag, input bit pin, input logic [31:0] p_pc,
                        input logic [31:0] p_instr, input logic p_valid, input logic p_ready);
        logic        v, r;
        logic [31:0] ins;
        int          n;
        bit          hw_take;
        @(negedge clk);
        model_eval(v, r, ins, n);
        chk({tag, " valid"}, 32'(bus.instr_valid_o), 32'(v));
        chk({tag, " ready"}, 32'(bus.fetch_ready_o), 32'(r));
        chk({tag, " pc"}, bus.pc_o, m_pc);
        if (v) chk({tag, " instr"}, bus.instr_aligned_o, ins);
        if (pin) begin
            chk({tag, " pin pc"}, bus.pc_o, p_pc);
            chk({tag, " pin valid"}, 32'(bus.instr_valid_o), 32'(p_valid));
            chk({tag, " pin ready"}, 32'(bus.fetch_ready_o), 32'(p_ready));
            if (p_valid) chk({tag, " pin instr"}, bus.instr_aligned_o, p_instr);
        end
        hw_take = 1'b0;
`ifdef CV32E40P_ALIGNER_HWLP_EN
        hw_take = bus.hwlp_update_pc_i && bus.if_valid_i && v;
`endif
        if (bus.branch_i) model_redirect(bus.branch_addr_i);
        else if (hw_take) model_redirect(bus.hwlp_addr_i);
        else if (bus.if_valid_i) begin
            if (r && bus.fetch_valid_i) begin
                if (!m_skip) m_q.push_back(bus.fetch_rdata_i[15:0]);
                m_q.push_back(bus.fetch_rdata_i[31:16]);
                m_skip = 1'b0;
            end
            if (v) begin
                for (int k = 0; k < n; k++) void'(m_q.pop_front());
                m_pc = m_pc + 32'(2 * n);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic br_to(input logic [31:0] a);
        drive(1'b0, 32'h0, 1'b0, 1'b1, a, 1'b0, 32'h0);
        tick("branch", 1'b1, bus.pc_o, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic word(input string tag, input logic fv, input logic [31:0] rd, input logic iv);
        drive(fv, rd, iv, 1'b0, 32'h0, 1'b0, 32'h0);
        tick(tag, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic wordp(input string tag, input logic fv, input logic [31:0] rd, input logic iv,
                         input logic [31:0] p_pc, input logic [31:0] p_instr,
                         input logic p_valid, input logic p_ready);
        drive(fv, rd, iv, 1'b0, 32'h0, 1'b0, 32'h0);
        tick(tag, 1'b1, p_pc, p_instr, p_valid, p_ready);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("reset pc", bus.pc_o, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wordp("idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Two aligned 32-bit instructions
        br_to(32'h100);
        wordp("al32 a", 1'b1, 32'h0000_0013, 1'b1, 32'h100, 32'h0000_0013, 1'b1, 1'b1);
        wordp("al32 b", 1'b1, 32'h00A0_0093, 1'b1, 32'h104, 32'h00A0_0093, 1'b1, 1'b1);

        // Compressed then straddling 32-bit
        br_to(32'h200);
        wordp("c then 32 a", 1'b1, 32'h0013_4501, 1'b1, 32'h200, 32'h0000_4501, 1'b1, 1'b1);
        wordp("c then 32 b", 1'b1, 32'h0000_0000, 1'b1, 32'h202, 32'h0000_0013, 1'b1, 1'b1);

        // Compressed from the buffered half with an empty prefetch buffer
        br_to(32'h500);
        wordp("buf c a", 1'b1, 32'h4509_4501, 1'b1, 32'h500, 32'h0000_4501, 1'b1, 1'b1);
        wordp("buf c b", 1'b0, 32'h0, 1'b1, 32'h502, 32'h0000_4509, 1'b1, 1'b0);
        wordp("buf c c", 1'b1, 32'h0000_0013, 1'b1, 32'h504, 32'h0000_0013, 1'b1, 1'b1);

        // Redirect to an odd halfword, compressed target
        br_to(32'h302);
        wordp("mis16 c", 1'b1, 32'h4505_0000, 1'b1, 32'h302, 32'h0000_4505, 1'b1, 1'b1);
        wordp("mis16 c next", 1'b1, 32'h0000_0013, 1'b1, 32'h304, 32'h0000_0013, 1'b1, 1'b1);

        // Redirect to an odd halfword, straddling 32-bit target
        br_to(32'h302);
        wordp("mis16 32 a", 1'b1, 32'h0013_0000, 1'b1, 32'h302, 32'h0, 1'b0, 1'b1);
        wordp("mis16 32 b", 1'b1, 32'h4501_0000, 1'b1, 32'h302, 32'h0000_0013, 1'b1, 1'b1);
        wordp("mis16 32 c", 1'b0, 32'h0, 1'b1, 32'h306, 32'h0000_4501, 1'b1, 1'b0);

        // Branch and hardware loop together while a half is buffered
        br_to(32'h200);
        word("pre both", 1'b1, 32'h0013_4501, 1'b1);
        drive(1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h600, 1'b1, 32'h402);
        tick("both", 1'b1, 32'h202, 32'h0, 1'b0, 1'b0);
        wordp("after both", 1'b1, 32'h0000_0013, 1'b1, 32'h600, 32'h0000_0013, 1'b1, 1'b1);

        // Hardware-loop jump on an issuing instruction
        br_to(32'h700);
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0, 1'b1, 32'h402);
        tick("hwlp", 1'b1, 32'h700, 32'h0000_0013, 1'b1, 1'b1);
`ifdef CV32E40P_ALIGNER_HWLP_EN
        wordp("hwlp after", 1'b1, 32'h4505_0000, 1'b1, 32'h402, 32'h0000_4505, 1'b1, 1'b1);
`else
        wordp("hwlp after", 1'b1, 32'h4505_0000, 1'b1, 32'h704, 32'h0000_0000, 1'b1, 1'b1);
`endif

        // pc wrap at the top of the address space
        br_to(32'hFFFF_FFFE);
        wordp("wrap a", 1'b1, 32'h4505_0000, 1'b1, 32'hFFFF_FFFE, 32'h0000_4505, 1'b1, 1'b1);
        wordp("wrap b", 1'b1, 32'h0000_0013, 1'b1, 32'h0, 32'h0000_0013, 1'b1, 1'b1);

        // Asynchronous reset while a half is buffered
        br_to(32'h200);
        word("pre rst", 1'b1, 32'h0013_4501, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid reset pc", bus.pc_o, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wordp("post rst", 1'b1, 32'h0000_0013, 1'b1, 32'h0, 32'h0000_0013, 1'b1, 1'b1);
        wordp("post rst b", 1'b1, 32'h0000_4501, 1'b1, 32'h4, 32'h0000_4501, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
